// File: rtl/gate_tb_pkg.sv
// Shared definitions for the gate stimulus sequencers.
// Contents:
//   - FSM state encodings (ST_*) and the typed state enum built from them
//   - settle counter width
//   - truth-table constants for the common gate cells; bit k is the
//     expected gate output when the input vector equals k
package gate_tb_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_WAIT  = 2'd1;
  localparam logic [1:0] ST_CHECK = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  typedef enum logic [1:0] {
    StIdle  = ST_IDLE,
    StWait  = ST_WAIT,
    StCheck = ST_CHECK,
    StDone  = ST_DONE
  } state_e;

  localparam int unsigned CNT_W = 4;

  localparam logic [3:0] TT_AND2 = 4'h8;
  localparam logic [7:0] TT_AND3 = 8'h80;
  localparam logic [3:0] TT_OR2  = 4'hE;
  localparam logic [7:0] TT_OR3  = 8'hFE;

endpackage

// File: rtl/gate_vec_settle_timer.sv
// Settle timer for the gate vector sequencer: a 4-bit loadable up-counter.
// Priority: clear, then load, then count enable.
// Ports:
//   i_clk       clock, rising edge
//   i_rst       synchronous active-high reset (count -> 0)
//   i_clr       synchronous clear
//   i_load      load i_load_val
//   i_load_val  value to load
//   i_en        count enable
//   o_term      high while the count equals SETTLE-1
module gate_vec_settle_timer
  import gate_tb_pkg::*;
#(
  parameter int unsigned SETTLE = 2
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_clr,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_val,
  input  logic             i_en,
  output logic             o_term
);

  localparam logic [CNT_W-1:0] TERM_VAL = CNT_W'(SETTLE - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (i_clr) begin
      cnt_d = '0;
    end else if (i_load) begin
      cnt_d = i_load_val;
    end else if (i_en) begin
      cnt_d = cnt_q + CNT_ONE;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign o_term = (cnt_q == TERM_VAL);

endmodule

// File: rtl/gate_vector_driver.sv
// Clocked stimulus/check sequencer for an N_IN-input combinational gate.
// Sweeps vectors 0..2**N_IN-1 onto o_vec, holds each SETTLE+1 cycles,
// samples i_dut in the last of them and compares against EXPECTED[vec].
// Ports:
//   i_clk         clock, rising edge
//   i_rst         synchronous active-high reset
//   i_start       start request, accepted only in IDLE
//   o_vec         vector driven onto the gate inputs (bit 0 -> i_1, ...)
//   i_dut         gate output under test
//   o_busy        sweep in progress
//   o_done        one-cycle pulse at sweep end
//   o_pass        last sweep had zero mismatches
//   o_err_cnt     mismatch count of the last/current sweep
//   o_fail_vld    at least one mismatch recorded
//   o_first_fail  vector index of the first mismatch
module gate_vector_driver
  import gate_tb_pkg::*;
#(
  parameter int unsigned N_IN = 3,
  parameter int unsigned SETTLE = 2,
  parameter logic [2**N_IN-1:0] EXPECTED = 8'b1000_0000
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_start,
  output logic [N_IN-1:0] o_vec,
  input  logic            i_dut,
  output logic            o_busy,
  output logic            o_done,
  output logic            o_pass,
  output logic [N_IN:0]   o_err_cnt,
  output logic            o_fail_vld,
  output logic [N_IN-1:0] o_first_fail
);

  localparam logic [N_IN-1:0] VEC_LAST = '1;
  localparam logic [N_IN-1:0] VEC_ONE  = N_IN'(1);
  localparam logic [N_IN:0]   ERR_ONE  = (N_IN+1)'(1);

  state_e          state_q, state_d;
  logic [N_IN-1:0] vec_q, vec_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            pass_q, pass_d;
  logic [N_IN:0]   err_q, err_d;
  logic            fail_vld_q, fail_vld_d;
  logic [N_IN-1:0] first_q, first_d;

  logic tmr_clr, tmr_en, tmr_term;

  gate_vec_settle_timer #(
    .SETTLE (SETTLE)
  ) u_settle_timer (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_clr      (tmr_clr),
    .i_load     (1'b0),
    .i_load_val ('0),
    .i_en       (tmr_en),
    .o_term     (tmr_term)
  );

  always_comb begin
    state_d    = state_q;
    vec_d      = vec_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    pass_d     = pass_q;
    err_d      = err_q;
    fail_vld_d = fail_vld_q;
    first_d    = first_q;
    tmr_clr    = 1'b0;
    tmr_en     = 1'b0;

    unique case (state_q)
      StIdle: begin
        vec_d  = '0;
        busy_d = 1'b0;
        if (i_start) begin
          state_d    = StWait;
          busy_d     = 1'b1;
          pass_d     = 1'b0;
          err_d      = '0;
          fail_vld_d = 1'b0;
          first_d    = '0;
          tmr_clr    = 1'b1;
        end
      end
      StWait: begin
        // Counter sits at SETTLE-1 on the last WAIT cycle; CHECK re-clears it.
        if (tmr_term) begin
          state_d = StCheck;
        end else begin
          tmr_en = 1'b1;
        end
      end
      StCheck: begin
        if (i_dut != EXPECTED[vec_q]) begin
          err_d = err_q + ERR_ONE;
          if (!fail_vld_q) begin
            fail_vld_d = 1'b1;
            first_d    = vec_q;
          end
        end
        if (vec_q == VEC_LAST) begin
          state_d = StDone;
        end else begin
          vec_d   = vec_q + VEC_ONE;
          tmr_clr = 1'b1;
          state_d = StWait;
        end
      end
      StDone: begin
        done_d  = 1'b1;
        pass_d  = (err_q == '0);
        busy_d  = 1'b0;
        vec_d   = '0;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= StIdle;
      vec_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
      err_q      <= '0;
      fail_vld_q <= 1'b0;
      first_q    <= '0;
    end else begin
      state_q    <= state_d;
      vec_q      <= vec_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      pass_q     <= pass_d;
      err_q      <= err_d;
      fail_vld_q <= fail_vld_d;
      first_q    <= first_d;
    end
  end

  assign o_vec        = vec_q;
  assign o_busy       = busy_q;
  assign o_done       = done_q;
  assign o_pass       = pass_q;
  assign o_err_cnt    = err_q;
  assign o_fail_vld   = fail_vld_q;
  assign o_first_fail = first_q;

endmodule

// File: doc/gate_vector_driver.md
Name: gate_vector_driver

Overview:
- Self-checking stimulus stage that sits directly upstream of the combinational gate cells (and_gate, and3_gate, or_gate).
- Sweeps every input combination of an N-input gate onto the DUT inputs and waits a settle time for each one.
- Samples the DUT output, compares it against a parameterised truth table, and reports pass/fail, error count and first failing vector.
- Replaces hand-written delay-based stimulus with a synthesizable, clocked sequencer.

Parameters:
- N_IN, 3, number of DUT inputs (legal 1..8).
- SETTLE, 2, cycles each vector is held before sampling (legal 1..15).
- EXPECTED, 8'b1000_0000, truth table of width 2**N_IN; bit k = expected DUT output for vector k (default = 3-input AND).

Ports:
- i_clk  in  1  clock, rising edge.
- i_rst  in  1  synchronous active-high reset.
- i_start  in  1  start request; sampled only in IDLE.
- o_vec  out  N_IN  DUT input vector; bit 0 drives i_1, bit 1 drives i_2, etc.
- i_dut  in  1  DUT output (o of the gate under test).
- o_busy  out  1  high while a sweep is running.
- o_done  out  1  one-cycle pulse at sweep end.
- o_pass  out  1  1 when the last sweep had zero mismatches.
- o_err_cnt  out  N_IN+1  mismatch count of the last or current sweep.
- o_fail_vld  out  1  at least one mismatch has been recorded.
- o_first_fail  out  N_IN  vector index of the first mismatch.

Behaviour:
- Reset: all outputs 0; state IDLE; internal settle counter 0. Reset is synchronous and active-high and overrides everything, including mid-sweep. All outputs return to 0 on the clock edge after i_rst is sampled high. Reset has priority over a simultaneous i_start.
- States:
  - IDLE: o_busy=0, o_vec=0. i_start=1 on an edge → WAIT, with o_vec=0, o_err_cnt=0, o_fail_vld=0, o_first_fail=0, o_pass=0, settle counter=0, and o_busy=1 from the next cycle.
  - WAIT: settle counter increments each cycle. When the counter reaches SETTLE-1 → CHECK.
  - CHECK: compare i_dut with EXPECTED[o_vec].
    - On mismatch: o_err_cnt += 1; if o_fail_vld==0, set o_first_fail=o_vec and o_fail_vld=1.
    - If o_vec == 2**N_IN-1 → DONE. Otherwise o_vec += 1, counter=0 → WAIT.
  - DONE: o_done=1 for exactly one cycle; o_pass = (o_err_cnt==0); o_busy=0; → IDLE.
- Timing:
  - Each vector is held for exactly SETTLE+1 cycles and i_dut is sampled in the last of them.
  - The start edge to the o_done pulse is 2**N_IN*(SETTLE+1)+1 cycles.
- o_vec returns to 0 in IDLE after DONE.
- o_pass, o_err_cnt, o_fail_vld and o_first_fail hold their values until the next accepted start or reset.
- i_start is ignored in WAIT, CHECK and DONE; there is no queuing. A start in the same cycle as DONE is ignored; it must be reasserted in IDLE.
- o_err_cnt is N_IN+1 bits wide, so the maximum of 2**N_IN never overflows.
- The vector counter does not wrap within a sweep; the terminal vector always exits to DONE.
- i_dut is sampled only in CHECK; glitches in WAIT have no effect.

Decomposition:
- Shared package gate_tb_pkg holds:
  - state encoding localparams ST_IDLE=2'd0, ST_WAIT=2'd1, ST_CHECK=2'd2, ST_DONE=2'd3;
  - the truth-table constants TT_AND2=4'h8, TT_AND3=8'h80, TT_OR2=4'hE, TT_OR3=8'hFE, reused by all gate benches.
- One sub-module, gate_vec_settle_timer: a 4-bit loadable counter with clear and a terminal flag at SETTLE-1. It is instantiated once.
- FSM, vector counter and error bookkeeping stay in the top module.

Test Plan:
- N_IN=3, SETTLE=2, EXPECTED=TT_AND3, driving and3_gate; pulse i_start → o_done after 25 cycles, o_pass=1, o_err_cnt=0, o_fail_vld=0, o_vec sequence 0..7 with each value held 3 cycles.
- Same config, but o_vec drives or3 logic instead → o_err_cnt=6, o_first_fail=3'd1, o_fail_vld=1, o_pass=0.
- N_IN=2, SETTLE=1, EXPECTED=TT_OR2, driving or_gate → done after 9 cycles, o_pass=1; vector 2'b10 gives i_dut=1 at its CHECK.
- i_dut tied 0, EXPECTED=TT_AND3 → o_err_cnt=1, o_first_fail=3'd7, o_pass=0.
- Start pulses re-asserted at cycles 5 and 12 of a running sweep → ignored; a single o_done arrives at the original cycle with unchanged results.
- Assert i_rst for 1 cycle during vector 4 → next cycle all outputs 0 and state IDLE; a fresh i_start then completes a clean sweep with o_pass=1.
